// File: rtl/mac_seq_ctrl.sv
// Sequencing controller for the eight-lane MAC array and its output serializer.
// Generates operand reads, skewed per-lane clear/enable strobes and serializer select/address.
module mac_seq_ctrl #(
  parameter int N     = 8,
  parameter int K     = 8,
  parameter int R_MAX = 8,
  parameter int AW    = 6,
  parameter int OW    = 6
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [3:0]           num_rows,
  output logic                 busy,
  output logic                 done,
  output logic                 rd_en,
  output logic [AW-1:0]        a_addr,
  output logic [$clog2(K)-1:0] b_addr,
  output logic [N-1:0]         mac_clr,
  output logic [N-1:0]         mac_en,
  output logic                 out_valid,
  output logic [2:0]           out_sel,
  output logic [OW-1:0]        out_addr
);

  localparam int KW = $clog2(K);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;

  state_t         state;
  logic [3:0]     rows;
  logic [3:0]     row;
  logic [N-1:0]   last_pipe;
  logic [OW-1:0]  out_cnt;

  logic           row_end;
  logic           last_rd;
  logic           fire;
  logic [2:0]     fire_sel;
  logic           drain_end;
  logic [3:0]     rows_clamped;

  always_comb begin
    rows_clamped = (num_rows > 4'(R_MAX)) ? 4'(R_MAX) : num_rows;
    row_end      = rd_en && (b_addr == KW'(K - 1));
    last_rd      = row_end && (row == rows - 4'd1);
    // last_pipe marks each lane's final accumulate cycle; at most one lane
    // is marked at a time because lanes are skewed by one and N <= K.
    fire         = |last_pipe;
    fire_sel     = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (last_pipe[i]) fire_sel = 3'(i);
    end
    drain_end    = out_valid && (int'(out_addr) == int'(rows) * N - 1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rows      <= '0;
      row       <= '0;
      last_pipe <= '0;
      out_cnt   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      rd_en     <= 1'b0;
      a_addr    <= '0;
      b_addr    <= '0;
      mac_clr   <= '0;
      mac_en    <= '0;
      out_valid <= 1'b0;
      out_sel   <= '0;
      out_addr  <= '0;
    end else begin
      // Lane strobes are the read strobe delayed by 1+i cycles, since
      // operand data arrives one cycle after its read.
      mac_en[0]    <= rd_en;
      mac_clr[0]   <= rd_en && (b_addr == '0);
      last_pipe[0] <= row_end;
      for (int unsigned i = 1; i < N; i++) begin
        mac_en[i]    <= mac_en[i-1];
        mac_clr[i]   <= mac_clr[i-1];
        last_pipe[i] <= last_pipe[i-1];
      end

      out_valid <= fire;
      if (fire) begin
        out_sel  <= fire_sel;
        out_addr <= out_cnt;
        out_cnt  <= out_cnt + OW'(1);
      end

      done <= 1'b0;

      case (state)
        IDLE: begin
          if (start) begin
            rows    <= rows_clamped;
            row     <= '0;
            out_cnt <= '0;
            a_addr  <= '0;
            b_addr  <= '0;
            if (rows_clamped == 4'd0) begin
              state <= FIN;
              done  <= 1'b1;
            end else begin
              state <= RUN;
              busy  <= 1'b1;
              rd_en <= 1'b1;
            end
          end
        end
        RUN: begin
          if (last_rd) begin
            rd_en <= 1'b0;
            state <= DRAIN;
          end else if (row_end) begin
            b_addr <= '0;
            row    <= row + 4'd1;
            a_addr <= a_addr + AW'(1);
          end else begin
            b_addr <= b_addr + KW'(1);
            a_addr <= a_addr + AW'(1);
          end
        end
        DRAIN: begin
          if (drain_end) begin
            state <= FIN;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        FIN: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
